// File: rtl/bcd_gate_counter_if.sv
// Bus bundle between the gated BCD event counter and its user (stimulus side
// drives the event input and hold, display side reads the latched result).
interface bcd_gate_counter_if;
  logic       sig_in;
  logic       hold;
  logic [9:0] bcd_out;
  logic       ovf;
  logic       valid;

  modport master (
    output sig_in,
    output hold,
    input  bcd_out,
    input  ovf,
    input  valid
  );

  modport slave (
    input  sig_in,
    input  hold,
    output bcd_out,
    output ovf,
    output valid
  );
endinterface

// File: rtl/bcd_gate_counter.sv
// Gated event counter: counts synchronised rising edges of sig_in over a fixed
// window in saturating 3-digit BCD and latches the result each window.
module bcd_gate_counter #(
  parameter int unsigned GATE_CYCLES = 50_000_000
) (
  input logic            clk,
  input logic            rst_n,
  bcd_gate_counter_if.slave bus
);

  localparam int unsigned   GW    = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {GATE, LATCH, CLEAR} state_t;

  state_t        state_q, state_d;
  logic          s1_q, s2_q, d_q;
  logic          rise;
  logic [1:0]    h_q, h_d;
  logic [3:0]    t_q, t_d;
  logic [3:0]    u_q, u_d;
  logic          ovfacc_q, ovfacc_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [9:0]    bcd_q, bcd_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;

  assign rise = s2_q & ~d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      s1_q <= bus.sig_in;
      s2_q <= s1_q;
      d_q  <= s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= GATE;
      h_q      <= '0;
      t_q      <= '0;
      u_q      <= '0;
      ovfacc_q <= 1'b0;
      gcnt_q   <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      t_q      <= t_d;
      u_q      <= u_d;
      ovfacc_q <= ovfacc_d;
      gcnt_q   <= gcnt_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    t_d      = t_q;
    u_d      = u_q;
    ovfacc_d = ovfacc_q;
    gcnt_d   = gcnt_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;

    case (state_q)
      GATE: begin
        gcnt_d = gcnt_q + GW'(1);
        if (rise) begin
          // 299 is sticky: further events only raise the overflow flag
          if (h_q == 2'd2 && t_q == 4'd9 && u_q == 4'd9) begin
            ovfacc_d = 1'b1;
          end else if (u_q == 4'd9) begin
            u_d = '0;
            if (t_q == 4'd9) begin
              t_d = '0;
              h_d = h_q + 2'd1;
            end else begin
              t_d = t_q + 4'd1;
            end
          end else begin
            u_d = u_q + 4'd1;
          end
        end
        if (gcnt_q == GLAST) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (!bus.hold) begin
          bcd_d   = {h_q, t_q, u_q};
          ovf_d   = ovfacc_q;
          valid_d = 1'b1;
        end
        state_d = CLEAR;
      end
      CLEAR: begin
        h_d      = '0;
        t_d      = '0;
        u_d      = '0;
        ovfacc_d = 1'b0;
        gcnt_d   = '0;
        state_d  = GATE;
      end
      default: begin
        state_d = GATE;
      end
    endcase
  end

  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;
  assign bus.valid   = valid_q;

endmodule

// File: tb/tb_bcd_gate_counter.sv
// Self-checking bench: two counters (100- and 1000-cycle windows), window-aligned
// pulse stimulus, expected results queued per window and compared on valid.
module tb_bcd_gate_counter;

  logic clk = 1'b0;
  logic rst100_n;
  logic rst1k_n;

  always #5 clk = ~clk;

  bcd_gate_counter_if if100 ();
  bcd_gate_counter_if if1k ();

  bcd_gate_counter #(.GATE_CYCLES(100)) dut100 (
    .clk   (clk),
    .rst_n (rst100_n),
    .bus   (if100)
  );

  bcd_gate_counter #(.GATE_CYCLES(1000)) dut1k (
    .clk   (clk),
    .rst_n (rst1k_n),
    .bus   (if1k)
  );

  int checks = 0;
  int errors = 0;

  logic [10:0] q100[$];
  logic [10:0] q1k[$];
  logic [9:0]  last_bcd [2];
  logic        last_ovf [2];
  logic        pv100 = 1'b0;
  logic        pv1k  = 1'b0;

  typedef struct {
    int         n;
    int         step;
    bit         hold;
    logic [9:0] bcd;
    logic       ovf;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: decimal count -> {ovf, saturated BCD}
  function automatic logic [10:0] bcd_of(input int n);
    int h, t, u;
    if (n > 299) return {1'b1, 10'h299};
    h = n / 100;
    t = (n / 10) % 10;
    u = n % 10;
    return {1'b0, 2'(h), 4'(t), 4'(u)};
  endfunction

  function automatic logic [11:0] outs(input bit sel);
    if (sel) return {if1k.valid, if1k.ovf, if1k.bcd_out};
    return {if100.valid, if100.ovf, if100.bcd_out};
  endfunction

  // One full measurement window; iteration o's negedge precedes window edge o.
  task automatic run_window(input bit sel, input int n, input int step, input int first_o,
                            input int extra_o, input bit hold_v, input logic [10:0] exp);
    int g;
    logic p;
    logic [11:0] o_s;
    g = sel ? 1000 : 100;
    if (!hold_v) begin
      if (sel) q1k.push_back(exp);
      else     q100.push_back(exp);
      last_bcd[sel] = exp[9:0];
      last_ovf[sel] = exp[10];
    end
    for (int o = 0; o < g + 2; o++) begin
      @(negedge clk);
      o_s = outs(sel);
      if (o == g) chk("valid_before_latch", 32'(o_s[11]), 32'd0);
      if (o == g + 1) begin
        chk("valid_at_latch_edge", 32'(o_s[11]), 32'(!hold_v));
        if (hold_v) begin
          chk("held_bcd", 32'(o_s[9:0]), 32'(last_bcd[sel]));
          chk("held_ovf", 32'(o_s[10]), 32'(last_ovf[sel]));
        end
      end
      p = ((o >= first_o) && ((o - first_o) % step == 0) && ((o - first_o) / step < n))
          || (o == extra_o);
      if (sel) begin
        if1k.sig_in = p;
        if1k.hold   = hold_v;
      end else begin
        if100.sig_in = p;
        if100.hold   = hold_v;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [10:0] e;
    if (pv100) chk("valid_width100", 32'(if100.valid), 32'd0);
    if (if100.valid) begin
      if (q100.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid100 actual=1 expected=0 at %0t", $time);
      end else begin
        e = q100.pop_front();
        chk("bcd_out100", 32'(if100.bcd_out), 32'(e[9:0]));
        chk("ovf100", 32'(if100.ovf), 32'(e[10]));
      end
    end
    pv100 <= if100.valid;
  end

  always @(negedge clk) begin
    logic [10:0] e;
    if (pv1k) chk("valid_width1k", 32'(if1k.valid), 32'd0);
    if (if1k.valid) begin
      if (q1k.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid1k actual=1 expected=0 at %0t", $time);
      end else begin
        e = q1k.pop_front();
        chk("bcd_out1k", 32'(if1k.bcd_out), 32'(e[9:0]));
        chk("ovf1k", 32'(if1k.ovf), 32'(e[10]));
      end
    end
    pv1k <= if1k.valid;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL timeout actual=running expected=finished at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{n: 37,  step: 4, hold: 1'b0, bcd: 10'h037, ovf: 1'b0};
    tbl[1] = '{n: 100, step: 4, hold: 1'b0, bcd: 10'h100, ovf: 1'b0};
    tbl[2] = '{n: 199, step: 4, hold: 1'b0, bcd: 10'h199, ovf: 1'b0};
    tbl[3] = '{n: 450, step: 2, hold: 1'b0, bcd: 10'h299, ovf: 1'b1};
    tbl[4] = '{n: 5,   step: 4, hold: 1'b0, bcd: 10'h005, ovf: 1'b0};
    tbl[5] = '{n: 12,  step: 4, hold: 1'b0, bcd: 10'h012, ovf: 1'b0};
    tbl[6] = '{n: 40,  step: 4, hold: 1'b1, bcd: 10'h012, ovf: 1'b0};
    tbl[7] = '{n: 7,   step: 4, hold: 1'b0, bcd: 10'h007, ovf: 1'b0};
    tbl[8] = '{n: 299, step: 2, hold: 1'b0, bcd: 10'h299, ovf: 1'b0};
    tbl[9] = '{n: 300, step: 2, hold: 1'b0, bcd: 10'h299, ovf: 1'b1};

    rst100_n     = 1'b0;
    rst1k_n      = 1'b0;
    if100.sig_in = 1'b0;
    if100.hold   = 1'b0;
    if1k.sig_in  = 1'b0;
    if1k.hold    = 1'b0;
    last_bcd[0] = '0; last_bcd[1] = '0;
    last_ovf[0] = 1'b0; last_ovf[1] = 1'b0;

    #3;
    chk("reset_bcd", 32'(if100.bcd_out), 32'd0);
    chk("reset_ovf", 32'(if100.ovf), 32'd0);
    chk("reset_valid", 32'(if100.valid), 32'd0);

    @(posedge clk); #1 rst100_n = 1'b1;
    run_window(1'b0, 20, 2, 0, -1, 1'b0, bcd_of(20));

    // Abort a window half way: outputs clear immediately, partial count lost
    for (int o = 0; o < 50; o++) begin
      @(negedge clk);
      if100.sig_in = (o % 2 == 0) && (o < 20);
    end
    chk("bcd_before_reset", 32'(if100.bcd_out), 32'(bcd_of(20) & 11'h3ff));
    #2 rst100_n = 1'b0;
    #1;
    chk("midreset_bcd", 32'(if100.bcd_out), 32'd0);
    chk("midreset_ovf", 32'(if100.ovf), 32'd0);
    chk("midreset_valid", 32'(if100.valid), 32'd0);
    @(posedge clk); #1 rst100_n = 1'b1;
    run_window(1'b0, 3, 2, 0, -1, 1'b0, bcd_of(3));

    // Final-GATE-cycle rise counts; LATCH-cycle rise is lost in both windows
    run_window(1'b0, 4, 2, 0, 97, 1'b0, bcd_of(5));
    run_window(1'b0, 5, 2, 0, 98, 1'b0, bcd_of(5));
    run_window(1'b0, 3, 2, 10, -1, 1'b0, bcd_of(3));
    rst100_n = 1'b0;

    @(posedge clk); #1 rst1k_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_window(1'b1, tbl[i].n, tbl[i].step, 0, -1, tbl[i].hold, {tbl[i].ovf, tbl[i].bcd});
    end

    @(negedge clk);
    chk("q100_drained", 32'(q100.size()), 32'd0);
    chk("q1k_drained", 32'(q1k.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_gate_counter.md
# bcd_gate_counter

Gated event counter that feeds the four-digit seven-segment scanning stage. It counts rising edges of an asynchronous input signal over a fixed window of clock cycles, accumulating directly in BCD. At each window end it latches the result into a 10-bit BCD display word: hundreds 0–2, tens 0–9, units 0–9, saturating at 299. The display word drives the scanner's 10-bit digit input unchanged.

## Interface
- GATE_CYCLES, default 50_000_000: gate window length in clk cycles (1 s at 50 MHz); legal range ≥ 2.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sig_in  in  1  asynchronous event input; each 0→1 transition is one event.
- hold  in  1  when high, result latching is suppressed (display frozen); counting continues.
- bcd_out  out  10  latched result: [9:8] hundreds (0–2), [7:4] tens, [3:0] units.
- ovf  out  1  latched with bcd_out; 1 = window saw more than 299 events.
- valid  out  1  one-cycle pulse, high in the cycle bcd_out first shows a new result.

## Operation
- Input path: sig_in → two-flop synchronizer (s1, s2) → delay flop d; rise = s2 & ~d.
- Accumulator: three BCD digits (h 2 bits, t 4 bits, u 4 bits) plus ovf_acc.
  - Increment on rise only in state GATE.
  - u = 9 → u = 0 and carry into t; t = 9 with carry → t = 0 and carry into h.
  - At 2/9/9, an increment leaves digits at 299 and sets ovf_acc = 1. Digits never exceed 299; no wrap to 000.
- Gate counter gcnt: width $clog2(GATE_CYCLES); counts 0..GATE_CYCLES-1 in GATE only.
- FSM states:
  - GATE: gcnt increments each cycle. When gcnt == GATE_CYCLES-1, go to LATCH. A rise in this final cycle is counted.
  - LATCH (1 cycle): if hold = 0, bcd_out ← {h,t,u}, ovf ← ovf_acc, valid ← 1 at this edge. If hold = 1, bcd_out/ovf unchanged and valid stays 0. Go to CLEAR.
  - CLEAR (1 cycle): h,t,u,ovf_acc,gcnt ← 0. Go to GATE.
- Rises occurring while in LATCH or CLEAR are discarded (2-cycle dead time per window).
- hold is sampled only in LATCH; toggling it elsewhere has no effect.

## Timing
- Reset (rst_n low, asynchronous): bcd_out = 0, ovf = 0, valid = 0. Accumulators, gcnt, and synchronizer flops cleared. State = GATE.
- Reset release: the first window starts at the first clk edge with rst_n high and is a full GATE_CYCLES long.
- Reset mid-window: the partial count is discarded; no valid pulse is emitted.
- Measurement period = GATE_CYCLES + 2 cycles; valid period is identical when hold = 0.
- Input latency: sig_in high before edge N → s1 at N, s2 at N+1, counted at edge N+2 if the state is GATE during the cycle after N+1.
- Result latency: bcd_out and valid update on the LATCH edge, one cycle after the last GATE cycle. valid falls on the following edge (CLEAR).
- sig_in pulses must be high ≥ 1 cycle and low ≥ 1 cycle to be counted. Narrower pulses may be missed; this is not an error.

## Test plan
Simulation runs with GATE_CYCLES = 100 unless stated otherwise.
- Reset: drive rst_n low mid-window with all outputs non-zero → bcd_out = 0, ovf = 0, valid = 0 with no clk edge needed. After release, the first valid appears exactly 101 cycles later (100 GATE cycles + LATCH edge).
- Basic count: 37 pulses (1 high / 3 low), all inside GATE → bcd_out = 10'b00_0011_0111, ovf = 0, valid high for exactly 1 cycle.
- BCD carry, GATE_CYCLES = 1000: exactly 100 pulses → bcd_out = 10'b01_0000_0000. Exactly 199 pulses → 10'b01_1001_1001.
- Saturation, GATE_CYCLES = 1000: sig_in toggles every cycle (500 rises) → bcd_out = 10'b10_1001_1001, ovf = 1. The next window with 5 pulses → bcd_out = 10'b00_0000_0101, ovf = 0.
- Hold: window 1 gives 12 events with hold = 0; window 2 gives 40 events with hold = 1 through LATCH → bcd_out stays 10'b00_0001_0010 and valid stays 0. Window 3 gives 7 events with hold = 0 → bcd_out = 10'b00_0000_0111.
- Dead time: a single rise timed to reach s2 in the LATCH cycle → it is not counted in either window. A rise counted at gcnt = 99 → it is included in the current result.
